id_scoreboard: RTL and testbench

- Register-pending scoreboard beside the decode stage, for multi-cycle producers (loads, mult/div, future coprocessor ops).
- Tracks, per architectural register, the cycles remaining until its result is forwardable.
- Raises stallReq when a decoded instruction reads a register that is still pending.
- Generalises single-cycle EX/MEM forwarding to arbitrary producer latency and register-file size.

---
 rtl/id_scoreboard.sv | 123 ++++++++++++
 tb/tb_id_scoreboard.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// Register-pending scoreboard for the decode stage.
// Each architectural register has a down-counter holding the number of cycles a
// consumer must still wait before the producer's result can be forwarded. A decoded
// instruction that reads a register whose counter is non-zero raises stallReq.
// A producer of latency L loads L-1, so a consumer stalls for cycles T+1 .. T+L-1
// and proceeds at T+L. L = 0 and L = 1 therefore never stall.
module id_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned LAT_W   = 3,
    parameter int unsigned MAX_LAT = 7,
    parameter int unsigned PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_wreg,
    input  logic [AW-1:0]     issue_wd,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic              rs1_read,
    input  logic [AW-1:0]     rs1_addr,
    input  logic              rs2_read,
    input  logic [AW-1:0]     rs2_addr,
    input  logic              flush,
    output logic              stallReq,
    output logic [NREG-1:0]   busy_mask,
    output logic [AW:0]       pending_cnt,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [AW:0]      NRegW   = (AW + 1)'(NREG);
    localparam logic [LAT_W-1:0] MaxLatW = LAT_W'(MAX_LAT);

    // Register 0 has no counter; cnt_view supplies a constant zero in its place.
    logic [LAT_W-1:0] cnt_q    [1:NREG-1];
    logic [LAT_W-1:0] cnt_d    [1:NREG-1];
    logic [LAT_W-1:0] cnt_view [NREG];

    logic              rs1_pend;
    logic              rs2_pend;
    logic              accept;
    logic              wr_en;
    logic [LAT_W-1:0]  lat_eff;
    logic [LAT_W-1:0]  load_val;
    logic [PERF_W-1:0] stall_cnt_q;

    // Full-size read view of the counters with register 0 tied to zero.
    always_comb begin
        cnt_view[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_view[r] = cnt_q[r];
        end
    end

    // Operand hazard lookup; addresses beyond the register file are never pending.
    always_comb begin
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        if ({1'b0, rs1_addr} < NRegW) begin
            rs1_pend = (cnt_view[rs1_addr] != '0);
        end
        if ({1'b0, rs2_addr} < NRegW) begin
            rs2_pend = (cnt_view[rs2_addr] != '0);
        end
    end

    // Stall decision and acceptance of the presented instruction.
    always_comb begin
        stallReq = issue_valid & ((rs1_read & rs1_pend) | (rs2_read & rs2_pend));
        accept   = issue_valid & ~stallReq & ~flush;
        wr_en    = accept & issue_wreg & (issue_wd != '0) & ({1'b0, issue_wd} < NRegW);
        lat_eff  = (issue_lat > MaxLatW) ? MaxLatW : issue_lat;
        load_val = (lat_eff == '0) ? '0 : lat_eff - LAT_W'(1);
    end

    // Next counter values: flush clears, otherwise decrement and merge a new
    // producer with the max rule so a younger write never looks ready earlier.
    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            if (flush) begin
                cnt_d[r] = '0;
            end else begin
                cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
                if (wr_en && (issue_wd == AW'(r)) && (load_val > cnt_d[r])) begin
                    cnt_d[r] = load_val;
                end
            end
        end
    end

    // Busy mask and population count of pending registers.
    always_comb begin
        busy_mask   = '0;
        pending_cnt = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
            pending_cnt  = pending_cnt + {{AW{1'b0}}, (cnt_q[r] != '0)};
        end
    end

    // Counter state; reset drops all pending writes without draining.
    always_ff @(posedge clk) begin
        for (int r = 1; r < NREG; r++) begin
            if (!rst) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Saturating stall-cycle counter; flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stallReq && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard. Each stimulus cycle pushes its expected
// outputs into a queue; a monitor on the falling edge pops and compares.
module tb_id_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_wreg;
    logic [4:0]  issue_wd;
    logic [3:0]  issue_lat;
    logic        rs1_read;
    logic [4:0]  rs1_addr;
    logic        rs2_read;
    logic [4:0]  rs2_addr;
    logic        flush;
    logic        stallReq;
    logic [23:0] busy_mask;
    logic [5:0]  pending_cnt;
    logic [1:0]  stall_cycles;

    id_scoreboard #(
        .NREG    (24),
        .AW      (5),
        .LAT_W   (4),
        .MAX_LAT (7),
        .PERF_W  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_wreg   (issue_wreg),
        .issue_wd     (issue_wd),
        .issue_lat    (issue_lat),
        .rs1_read     (rs1_read),
        .rs1_addr     (rs1_addr),
        .rs2_read     (rs2_read),
        .rs2_addr     (rs2_addr),
        .flush        (flush),
        .stallReq     (stallReq),
        .busy_mask    (busy_mask),
        .pending_cnt  (pending_cnt),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // A field set to -1 is not checked.
    typedef struct {
        int     id;
        int     stall;
        longint busy;
        int     pend;
        int     perf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   step_id = 0;

    task automatic chk(input string nm, input int id, input longint act, input longint req);
        if (req >= 0) begin
            n_cmp++;
            if (act != req) begin
                n_bad++;
                $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", nm, id, act, req);
            end
        end
    endtask

    // Monitor: one expectation per stimulus cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stallReq",     e.id, longint'(stallReq),     longint'(e.stall));
            chk("busy_mask",    e.id, longint'(busy_mask),    e.busy);
            chk("pending_cnt",  e.id, longint'(pending_cnt),  longint'(e.pend));
            chk("stall_cycles", e.id, longint'(stall_cycles), longint'(e.perf));
        end
    end

    task automatic idle();
        issue_valid = 1'b0;
        issue_wreg  = 1'b0;
        issue_wd    = '0;
        issue_lat   = '0;
        rs1_read    = 1'b0;
        rs1_addr    = '0;
        rs2_read    = 1'b0;
        rs2_addr    = '0;
        flush       = 1'b0;
    endtask

    task automatic iss(input int wd, input int lat);
        idle();
        issue_valid = 1'b1;
        issue_wreg  = 1'b1;
        issue_wd    = 5'(wd);
        issue_lat   = 4'(lat);
    endtask

    task automatic rd(input bit r1, input int a1, input bit r2, input int a2);
        idle();
        issue_valid = 1'b1;
        rs1_read    = r1;
        rs1_addr    = 5'(a1);
        rs2_read    = r2;
        rs2_addr    = 5'(a2);
    endtask

    task automatic expect_out(input int s, input longint b, input int p, input int f);
        exp_t e;
        e.id    = step_id;
        e.stall = s;
        e.busy  = b;
        e.pend  = p;
        e.perf  = f;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        step_id++;
    endtask

    initial begin
        // Reset held two cycles while an issue is presented.
        rst = 1'b0;
        iss(5, 3);                         tick();
        iss(5, 3); expect_out(0, 0, 0, 0); tick();
        rst = 1'b1;
        idle();    expect_out(0, 0, 0, 0); tick();

        // Load-use: lat 2 stalls exactly one cycle.
        iss(3, 2);          expect_out(0, 0, 0, 0);     tick();
        rd(1, 3, 0, 0);     expect_out(1, 'h8, 1, 0);   tick();
        rd(1, 3, 0, 0);     expect_out(0, 0, 0, 1);     tick();
        idle();             expect_out(0, 0, 0, 1);     tick();

        // WAW: lat 6 then lat 1 on r8 leaves 4 stall cycles; perf saturates at 3.
        iss(8, 6);          expect_out(0, 0, 0, 1);     tick();
        iss(8, 1);          expect_out(0, 'h100, 1, 1); tick();
        for (int i = 0; i < 4; i++) begin
            rd(1, 8, 0, 0);
            expect_out(1, 'h100, 1, (i + 1 > 3) ? 3 : i + 1);
            tick();
        end
        idle();             expect_out(0, 0, 0, 3);     tick();

        // Reset clears perf; zero register is never pending.
        rst = 1'b0; idle(); tick();
        rst = 1'b1;
        iss(0, 7);          expect_out(0, 0, 0, 0);     tick();
        rd(1, 0, 0, 0);     expect_out(0, 0, 0, 0);     tick();

        // Clamp: lat 12 behaves as lat 7, six stall cycles.
        iss(4, 12);         expect_out(0, 0, 0, 0);     tick();
        for (int i = 0; i < 6; i++) begin
            rd(0, 0, 1, 4);
            expect_out(1, 'h10, 1, (i > 3) ? 3 : i);
            tick();
        end
        idle();             expect_out(0, 0, 0, 3);     tick();

        // Flush with a concurrent issue: everything cleared, perf kept.
        iss(9, 7);          expect_out(0, 0, 0, 3);     tick();
        iss(2, 4);          expect_out(0, 'h200, 1, 3); tick();
        iss(10, 5); flush = 1'b1;
                            expect_out(0, 'h204, 2, 3); tick();
        rd(1, 9, 1, 10);    expect_out(0, 0, 0, 3);     tick();

        // Dual source: rs2 pending for two cycles; stalled write is held off.
        rst = 1'b0; idle(); tick();
        rst = 1'b1;
        iss(6, 3);          expect_out(0, 0, 0, 0);     tick();
        for (int i = 0; i < 3; i++) begin
            rd(1, 4, 1, 6);
            issue_wreg = 1'b1;
            issue_wd   = 5'd7;
            issue_lat  = 4'd5;
            expect_out((i < 2) ? 1 : 0, (i < 2) ? 'h40 : 0, (i < 2) ? 1 : 0, i);
            tick();
        end
        idle();             expect_out(0, 'h80, 1, 2);  tick();

        // Self-dependency does not stall on its own destination.
        iss(11, 4); rs1_read = 1'b1; rs1_addr = 5'd11;
                            expect_out(0, 'h80, 1, 2);  tick();
        idle();             expect_out(0, 'h880, 2, 2); tick();

        // Out-of-range register: not pending and never written.
        iss(30, 5); rs1_read = 1'b1; rs1_addr = 5'd30;
                            expect_out(0, 'h880, 2, 2); tick();
        idle();             expect_out(0, 'h800, 1, 2); tick();
        idle();             expect_out(0, 0, 0, 2);     tick();

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
